regfile_write_arbiter: RTL and testbench

Four-requestor write front-end for the single write port (ADDR_IN/D_IN/WE) of the multi-read-port register file. Each requestor writes through a valid/ready handshake into a one-entry holding register. A round-robin arbiter serialises held writes onto the registered write port. A sweep engine writes `init_value` to every address lo..hi after reset or on request. Read ports are untouched; consumers keep reading the register file directly.

---
 rtl/regfile_write_arbiter_if.sv | 25 ++
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Requestor-side write handshake bundle for the register-file write arbiter.
// Four valid/ready channels, each carrying one address/data pair.
interface regfile_write_arbiter_if #(
  parameter int addr_width = 5,
  parameter int data_width = 32
);
  logic [3:0]                 wreq_valid;
  logic [3:0][addr_width-1:0] wreq_addr;
  logic [3:0][data_width-1:0] wreq_data;
  logic [3:0]                 wreq_ready;

  modport master (
    output wreq_valid,
    output wreq_addr,
    output wreq_data,
    input  wreq_ready
  );

  modport slave (
    input  wreq_valid,
    input  wreq_addr,
    input  wreq_data,
    output wreq_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Four-requestor front-end for the single register-file write port: one-entry
// holding registers, round-robin arbitration, and an init sweep engine.
module regfile_write_arbiter #(
  parameter int                    addr_width = 5,
  parameter int                    data_width = 32,
  parameter int                    lo         = 0,
  parameter int                    hi         = 31,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  regfile_write_arbiter_if.slave wreq,
  input  logic                   CLR_REQ,
  output logic                   BUSY,
  output logic                   ERR,
  output logic [addr_width-1:0]  ADDR_IN,
  output logic [data_width-1:0]  D_IN,
  output logic                   WE
);

  typedef enum logic [1:0] {SWEEP, IDLE, DRAIN} state_t;

  localparam logic [addr_width-1:0] lo_addr = addr_width'(lo);
  localparam logic [addr_width-1:0] hi_addr = addr_width'(hi);

  state_t                     state;
  logic [addr_width-1:0]      sweep_cnt;
  logic [1:0]                 last_grant;
  logic [3:0]                 held;
  logic [3:0][addr_width-1:0] hold_addr;
  logic [3:0][data_width-1:0] hold_data;

  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic       grant_any;
  logic [3:0] ready;
  logic [3:0] accept;
  logic [3:0] in_range;
  logic [3:0] held_next;
  logic       err_set;

  // Signed 32-bit compare keeps the bound check meaningful for any lo/hi.
  function automatic logic addr_ok(input logic [addr_width-1:0] a);
    int v;
    v = int'(a);
    return (v >= lo) && (v <= hi);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant     = '0;
    grant_idx = last_grant;
    grant_any = 1'b0;
    cand      = '0;
    if (state != SWEEP) begin
      // Search starts just after the last winner; k=4 wraps back to it.
      for (int k = 1; k <= 4; k++) begin
        cand = last_grant + 2'(k);
        if (!grant_any && held[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    in_range = '0;
    for (int i = 0; i < 4; i++) in_range[i] = addr_ok(wreq.wreq_addr[i]);
  end

  // A granted slot can be refilled on the same edge it drains.
  assign ready     = (state == IDLE) ? (~held | grant) : 4'b0000;
  assign accept    = wreq.wreq_valid & ready;
  assign err_set   = |(accept & ~in_range);
  assign held_next = (held & ~grant) | (accept & in_range);

  assign wreq.wreq_ready = ready;
  assign BUSY            = (state != IDLE);

  // NOTE: payload registers carry no reset; held[] alone says whether they mean anything.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i] && in_range[i]) begin
        hold_addr[i] <= wreq.wreq_addr[i];
        hold_data[i] <= wreq.wreq_data[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= SWEEP;
      sweep_cnt  <= lo_addr;
      held       <= '0;
      last_grant <= 2'd3;
      WE         <= 1'b0;
      ADDR_IN    <= '0;
      D_IN       <= '0;
      ERR        <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          WE      <= 1'b1;
          ADDR_IN <= sweep_cnt;
          D_IN    <= init_value;
          if (sweep_cnt == hi_addr) state     <= IDLE;
          else                      sweep_cnt <= sweep_cnt + addr_width'(1);
        end
        IDLE, DRAIN: begin
          WE   <= grant_any;
          held <= held_next;
          if (grant_any) begin
            ADDR_IN    <= hold_addr[grant_idx];
            D_IN       <= hold_data[grant_idx];
            last_grant <= grant_idx;
          end
          if (state == IDLE) begin
            if (CLR_REQ) begin
              state <= DRAIN;
              ERR   <= 1'b0;
            end else if (err_set) begin
              ERR <= 1'b1;
            end
          end else if (held_next == 4'b0000) begin
            state     <= SWEEP;
            sweep_cnt <= lo_addr;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised, model-checked bench for regfile_write_arbiter, with directed
// scenarios pinned by hand-computed expectations.
module tb_regfile_write_arbiter;

  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam int          LO   = 2;
  localparam int          HI   = 29;
  localparam logic [31:0] INIT = 32'hC0DE_5A5A;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CLR_REQ;
  logic          BUSY, ERR, WE;
  logic [AW-1:0] ADDR_IN;
  logic [DW-1:0] D_IN;

  regfile_write_arbiter_if #(.addr_width(AW), .data_width(DW)) wif ();

  regfile_write_arbiter #(
    .addr_width(AW), .data_width(DW), .lo(LO), .hi(HI), .init_value(INIT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .wreq    (wif.slave),
    .CLR_REQ (CLR_REQ),
    .BUSY    (BUSY),
    .ERR     (ERR),
    .ADDR_IN (ADDR_IN),
    .D_IN    (D_IN),
    .WE      (WE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file as seen by a consumer of the write port.
  logic [DW-1:0] rf [32];
  always @(posedge CLK) if (WE === 1'b1) rf[ADDR_IN] <= D_IN;

  // ---------------- behavioural model ----------------
  bit            m_live = 1'b0;
  bit [3:0]      m_pend;
  logic [AW-1:0] m_addr [4];
  logic [DW-1:0] m_data [4];
  int            m_last;
  int            m_sweep [$];
  bit            m_drain, m_err;
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  function automatic bit m_idle();
    return !m_drain && (m_sweep.size() == 0);
  endfunction

  function automatic int pick();
    for (int k = 1; k <= 4; k++) begin
      int p = (m_last + k) % 4;
      if (m_pend[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    int g = pick();
    for (int i = 0; i < 4; i++) r[i] = m_idle() && (!m_pend[i] || g == i);
    return r;
  endfunction

  task automatic fill_sweep();
    m_sweep.delete();
    for (int a = LO; a <= HI; a++) m_sweep.push_back(a);
  endtask

  task automatic model_step();
    logic [3:0] rdy;
    int         g;
    bit         idle, errset;
    if (RST) begin
      m_live = 1'b1; m_pend = '0; m_last = 3; m_drain = 0; m_err = 0;
      e_we = 0; e_addr = '0; e_data = '0;
      fill_sweep();
      return;
    end
    if (m_sweep.size() != 0) begin
      e_we = 1; e_addr = AW'(m_sweep.pop_front()); e_data = INIT;
      return;
    end
    idle = m_idle(); g = pick(); rdy = m_ready(); errset = 0;
    if (g >= 0) begin
      e_we = 1; e_addr = m_addr[g]; e_data = m_data[g]; m_pend[g] = 0; m_last = g;
    end else begin
      e_we = 0;
    end
    if (idle) begin
      for (int i = 0; i < 4; i++) begin
        if (wif.wreq_valid[i] && rdy[i]) begin
          if (int'(wif.wreq_addr[i]) >= LO && int'(wif.wreq_addr[i]) <= HI) begin
            m_pend[i] = 1; m_addr[i] = wif.wreq_addr[i]; m_data[i] = wif.wreq_data[i];
          end else begin
            errset = 1;
          end
        end
      end
      if (CLR_REQ)     begin m_drain = 1; m_err = 0; end
      else if (errset) m_err = 1;
    end else if (m_pend == 4'b0000) begin
      m_drain = 0;
      fill_sweep();
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Single compare process: outputs are stable between edges, checked on the falling edge.
  initial forever begin
    @(negedge CLK);
    if (m_live) begin
      check("ctrl{we,busy,err,ready}", {WE, BUSY, ERR, wif.wreq_ready},
            {e_we, !m_idle(), m_err, m_ready()});
      check("addr_in", 64'(ADDR_IN), 64'(e_addr));
      check("d_in", 64'(D_IN), 64'(e_data));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic sweep_count(input int clr_at, output int cnt, output int first_a, output int last_a);
    cnt = 0; first_a = -1; last_a = -1;
    for (int n = 0; n < 200; n++) begin
      CLR_REQ = (n == clr_at);
      tick();
      if (WE) begin
        if (first_a < 0) first_a = int'(ADDR_IN);
        last_a = int'(ADDR_IN);
        cnt++;
      end
      if (!BUSY) break;
    end
    CLR_REQ = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input int cnt, input int first_a, input int last_a);
    check({tag, "_count"}, 64'(cnt), 64'(HI - LO + 1));
    check({tag, "_first"}, 64'(first_a), 64'(LO));
    check({tag, "_last"},  64'(last_a),  64'(HI));
  endtask

  int cnt, fa, la;
  int rr_cnt [4];
  int rr_we, rr_first;

  initial begin
    RST = 1'b1; CLR_REQ = 1'b0;
    wif.wreq_valid = '0; wif.wreq_addr = '0; wif.wreq_data = '0;

    // Reset state and post-reset sweep
    tick();
    check("reset_state", {WE, BUSY, ERR, wif.wreq_ready, ADDR_IN, D_IN}, {1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 32'd0});
    tick();
    RST = 1'b0;
    sweep_count(-1, cnt, fa, la);
    check_sweep("reset_sweep", cnt, fa, la);
    check("sweep_data", 64'(D_IN), 64'(INIT));
    check("ready_after_sweep", 64'(wif.wreq_ready), 64'h0F);

    // Single write on port 2
    wif.wreq_valid[2] = 1'b1; wif.wreq_addr[2] = 5'd5; wif.wreq_data[2] = 32'hDEADBEEF;
    tick();
    wif.wreq_valid = '0;
    tick();
    check("single_write_port", {WE, ADDR_IN, D_IN}, {1'b1, 5'd5, 32'hDEADBEEF});
    tick();
    check("single_write_rf", 64'(rf[5]), 64'hDEADBEEF);

    // Round-robin with all four ports continuously valid
    for (int i = 0; i < 4; i++) begin
      wif.wreq_valid[i] = 1'b1; wif.wreq_addr[i] = AW'(8 + i); wif.wreq_data[i] = 32'(16 + i);
      rr_cnt[i] = 0;
    end
    tick();
    rr_we = 0; rr_first = -1;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (WE) begin
        rr_we++;
        if (rr_first < 0) rr_first = int'(ADDR_IN) - 8;
        if (ADDR_IN >= 5'd8 && ADDR_IN <= 5'd11) rr_cnt[int'(ADDR_IN) - 8]++;
      end
    end
    wif.wreq_valid = '0;
    check("rr_we_every_cycle", 64'(rr_we), 64'd16);
    check("rr_first_grant", 64'(rr_first), 64'd3);
    for (int i = 0; i < 4; i++) check($sformatf("rr_share_port%0d", i), 64'(rr_cnt[i]), 64'd4);
    repeat (6) tick();

    // Same-address ordering: make port 0 the last winner, then ports 1 and 3 race on addr 7
    wif.wreq_valid[0] = 1'b1; wif.wreq_addr[0] = 5'd3; wif.wreq_data[0] = 32'h33;
    tick();
    wif.wreq_valid = '0;
    repeat (2) tick();
    wif.wreq_valid[1] = 1'b1; wif.wreq_addr[1] = 5'd7; wif.wreq_data[1] = 32'hAA;
    wif.wreq_valid[3] = 1'b1; wif.wreq_addr[3] = 5'd7; wif.wreq_data[3] = 32'hBB;
    tick();
    wif.wreq_valid = '0;
    tick();
    check("same_addr_first", {WE, ADDR_IN, D_IN}, {1'b1, 5'd7, 32'hAA});
    tick();
    check("same_addr_second", {WE, ADDR_IN, D_IN}, {1'b1, 5'd7, 32'hBB});
    tick();
    check("same_addr_rf", 64'(rf[7]), 64'hBB);

    // Out-of-range on both sides, boundaries in range on the other ports
    wif.wreq_valid = 4'hF;
    wif.wreq_addr[0] = AW'(HI + 1); wif.wreq_addr[1] = AW'(LO - 1);
    wif.wreq_addr[2] = AW'(LO);     wif.wreq_addr[3] = AW'(HI);
    wif.wreq_data[2] = 32'h2222;    wif.wreq_data[3] = 32'h3333;
    tick();
    wif.wreq_valid = '0;
    check("oor_err_set", {WE, ERR}, {1'b0, 1'b1});
    repeat (4) tick();
    check("oor_err_sticky", 64'(ERR), 64'd1);
    check("boundary_rf_hi", 64'(rf[HI]), 64'h3333);

    // Clear with pending writes plus a simultaneous out-of-range offer
    wif.wreq_valid = 4'b0111;
    wif.wreq_addr[0] = 5'd10; wif.wreq_data[0] = 32'h1111_0000;
    wif.wreq_addr[1] = 5'd11; wif.wreq_data[1] = 32'h2222_0000;
    wif.wreq_addr[2] = 5'd31;
    CLR_REQ = 1'b1;
    tick();
    wif.wreq_valid = '0; CLR_REQ = 1'b0;
    check("clr_ready_err_busy", {wif.wreq_ready, ERR, BUSY}, {4'h0, 1'b0, 1'b1});
    tick();
    check("drain_port0", {WE, ADDR_IN, D_IN}, {1'b1, 5'd10, 32'h1111_0000});
    tick();
    check("drain_port1", {WE, ADDR_IN, D_IN}, {1'b1, 5'd11, 32'h2222_0000});
    sweep_count(5, cnt, fa, la);
    check_sweep("clr_sweep", cnt, fa, la);
    check("busy_after_clr_sweep", 64'(BUSY), 64'd0);

    // Reset in the middle of a sweep restarts it from lo
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    repeat (6) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_sweep_reset", {WE, BUSY}, {1'b0, 1'b1});
    sweep_count(-1, cnt, fa, la);
    check_sweep("restart_sweep", cnt, fa, la);

    // Randomised traffic, clears and resets against the model
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) begin
        wif.wreq_valid[i] = ($urandom_range(0, 3) != 0);
        wif.wreq_addr[i]  = AW'($urandom_range(0, 31));
        wif.wreq_data[i]  = $urandom;
      end
      CLR_REQ = ($urandom_range(0, 59) == 0);
      RST     = ($urandom_range(0, 399) == 0);
      tick();
    end
    wif.wreq_valid = '0; CLR_REQ = 1'b0; RST = 1'b0;
    for (int n = 0; n < 200 && BUSY; n++) tick();
    check("final_idle", 64'(BUSY), 64'd0);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
